// File: rtl/fx_delay_line.sv
// fx_delay_line: multi-channel RAM delay with feedback and dry/wet mix, one channel per 3-cycle slot.
// Optional build macro FX_DELAY_SAT_EN: saturate stored and output samples instead of two's-complement wrap.
module fx_delay_line #(
  parameter int DATA_W   = 16,
  parameter int PARAM_W  = 7,
  parameter int CHANNELS = 2,
  parameter int ADDR_W   = 12
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            sample_valid,
  input  logic [CHANNELS-1:0][DATA_W-1:0] audio_in,
  input  logic [PARAM_W-1:0]              delay_time,
  input  logic [PARAM_W-1:0]              feedback,
  input  logic [PARAM_W-1:0]              mix,
  output logic [CHANNELS-1:0][DATA_W-1:0] audio_out,
  output logic                            out_valid,
  output logic                            busy
);

  localparam int CH_BITS = $clog2(CHANNELS);
  localparam int CH_W    = (CH_BITS > 0) ? CH_BITS : 1;
  localparam int MEM_AW  = CH_BITS + ADDR_W;
  localparam int DEPTH   = CHANNELS * (2 ** ADDR_W);
  localparam int PROD_W  = DATA_W + PARAM_W + 2;
  localparam int SHIFT   = ADDR_W - PARAM_W;

  localparam logic [MEM_AW-1:0]        CLR_LAST = MEM_AW'(DEPTH - 1);
  localparam logic [CH_W-1:0]          CH_LAST  = CH_W'(CHANNELS - 1);
  localparam logic signed [PROD_W-1:0] UNITY    = PROD_W'(2 ** PARAM_W);
`ifdef FX_DELAY_SAT_EN
  localparam logic signed [PROD_W-1:0] SAT_MAX  = PROD_W'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [PROD_W-1:0] SAT_MIN  = ~SAT_MAX;
`endif

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_IDLE  = 3'd1,
    ST_RD    = 3'd2,
    ST_CALC  = 3'd3,
    ST_WR    = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Reduce a wide signed result to a sample: clamp or wrap depending on build.
  function automatic logic [DATA_W-1:0] reduce_sample(input logic signed [PROD_W-1:0] v);
`ifdef FX_DELAY_SAT_EN
    if (v > SAT_MAX) begin
      return {1'b0, {(DATA_W-1){1'b1}}};
    end else if (v < SAT_MIN) begin
      return {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      return v[DATA_W-1:0];
    end
`else
    return v[DATA_W-1:0];
`endif
  endfunction

  // Flat RAM address {ch, ptr}; for a single channel the channel field vanishes.
  function automatic logic [MEM_AW-1:0] mem_addr(input logic [CH_W-1:0] ch,
                                                 input logic [ADDR_W-1:0] ptr);
    logic [CH_W+ADDR_W-1:0] full;
    full = {ch, ptr};
    return full[MEM_AW-1:0];
  endfunction

  state_t                          state_r;
  logic [MEM_AW-1:0]               clr_cnt_r;
  logic [ADDR_W-1:0]               wr_ptr_r;
  logic [ADDR_W-1:0]               delay_r;
  logic [CH_W-1:0]                 ch_r;
  logic [CHANNELS-1:0][DATA_W-1:0] x_r;
  logic [CHANNELS-1:0][DATA_W-1:0] audio_out_r;
  logic [PARAM_W-1:0]              fb_r;
  logic [PARAM_W-1:0]              mix_r;
  logic signed [PROD_W-1:0]        fb_prod_r;
  logic signed [PROD_W-1:0]        mix_acc_r;
  logic                            out_valid_r;
  logic                            busy_r;

  logic [DATA_W-1:0]               mem_r [DEPTH];
  logic [DATA_W-1:0]               rd_data_r;

  logic [ADDR_W-1:0]               delay_s;
  logic [MEM_AW-1:0]               rd_addr_s;
  logic [MEM_AW-1:0]               wr_addr_s;
  logic                            wr_en_s;
  logic [DATA_W-1:0]               wr_data_s;
  logic [DATA_W-1:0]               x_sel_s;
  logic signed [PROD_W-1:0]        x_ext_s;
  logic signed [PROD_W-1:0]        y_ext_s;
  logic signed [PROD_W-1:0]        fb_ext_s;
  logic signed [PROD_W-1:0]        mix_ext_s;
  logic signed [PROD_W-1:0]        w_full_s;
  logic signed [PROD_W-1:0]        o_full_s;
  logic [DATA_W-1:0]               o_s;

  // Delay length from delay_time; zero is promoted to one sample.
  always_comb begin
    delay_s = {{(ADDR_W-1){1'b0}}, 1'b1};
    if (delay_time != {PARAM_W{1'b0}}) begin
      delay_s = ADDR_W'(delay_time) << SHIFT;
    end else begin
      delay_s = {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  end

  // Sign-extended operands and the post-product results for the current channel.
  always_comb begin
    x_sel_s   = x_r[ch_r];
    x_ext_s   = {{(PROD_W-DATA_W){x_sel_s[DATA_W-1]}}, x_sel_s};
    y_ext_s   = {{(PROD_W-DATA_W){rd_data_r[DATA_W-1]}}, rd_data_r};
    fb_ext_s  = {{(PROD_W-PARAM_W){1'b0}}, fb_r};
    mix_ext_s = {{(PROD_W-PARAM_W){1'b0}}, mix_r};
    w_full_s  = x_ext_s + (fb_prod_r >>> PARAM_W);
    o_full_s  = mix_acc_r >>> PARAM_W;
    o_s       = reduce_sample(o_full_s);
  end

  // RAM port control: zero-fill during CLEAR, delay-line write in WR, tap read always addressed.
  always_comb begin
    rd_addr_s = mem_addr(ch_r, wr_ptr_r - delay_r);
    wr_en_s   = 1'b0;
    wr_addr_s = mem_addr(ch_r, wr_ptr_r);
    wr_data_s = {DATA_W{1'b0}};
    case (state_r)
      ST_CLEAR: begin
        wr_en_s   = 1'b1;
        wr_addr_s = clr_cnt_r;
        wr_data_s = {DATA_W{1'b0}};
      end
      ST_WR: begin
        wr_en_s   = 1'b1;
        wr_addr_s = mem_addr(ch_r, wr_ptr_r);
        wr_data_s = reduce_sample(w_full_s);
      end
      default: begin
        wr_en_s   = 1'b0;
        wr_addr_s = mem_addr(ch_r, wr_ptr_r);
        wr_data_s = {DATA_W{1'b0}};
      end
    endcase
  end

  // Delay buffer: single write port, synchronous read with one cycle of latency, not reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_addr_s] <= wr_data_s;
    end
    rd_data_r <= mem_r[rd_addr_s];
  end

  // Frame sequencer with its registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_CLEAR;
      clr_cnt_r   <= {MEM_AW{1'b0}};
      wr_ptr_r    <= {ADDR_W{1'b0}};
      delay_r     <= {{(ADDR_W-1){1'b0}}, 1'b1};
      ch_r        <= {CH_W{1'b0}};
      x_r         <= {(CHANNELS*DATA_W){1'b0}};
      audio_out_r <= {(CHANNELS*DATA_W){1'b0}};
      fb_r        <= {PARAM_W{1'b0}};
      mix_r       <= {PARAM_W{1'b0}};
      fb_prod_r   <= {PROD_W{1'b0}};
      mix_acc_r   <= {PROD_W{1'b0}};
      out_valid_r <= 1'b0;
      busy_r      <= 1'b1;
    end else begin
      out_valid_r <= 1'b0;
      case (state_r)
        ST_CLEAR: begin
          if (clr_cnt_r == CLR_LAST) begin
            clr_cnt_r <= {MEM_AW{1'b0}};
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
          end else begin
            clr_cnt_r <= clr_cnt_r + MEM_AW'(1);
          end
        end
        ST_IDLE: begin
          if (sample_valid) begin
            x_r     <= audio_in;
            delay_r <= delay_s;
            fb_r    <= feedback;
            mix_r   <= mix;
            ch_r    <= {CH_W{1'b0}};
            state_r <= ST_RD;
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        ST_RD: begin
          state_r <= ST_CALC;
        end
        ST_CALC: begin
          fb_prod_r <= y_ext_s * fb_ext_s;
          mix_acc_r <= x_ext_s * (UNITY - mix_ext_s) + y_ext_s * mix_ext_s;
          state_r   <= ST_WR;
        end
        ST_WR: begin
          audio_out_r[ch_r] <= o_s;
          if (ch_r == CH_LAST) begin
            state_r     <= ST_DONE;
            out_valid_r <= 1'b1;
          end else begin
            ch_r    <= ch_r + CH_W'(1);
            state_r <= ST_RD;
          end
        end
        ST_DONE: begin
          wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
          state_r  <= ST_IDLE;
          busy_r   <= 1'b0;
        end
        default: begin
          state_r   <= ST_CLEAR;
          clr_cnt_r <= {MEM_AW{1'b0}};
          busy_r    <= 1'b1;
        end
      endcase
    end
  end

  assign audio_out = audio_out_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_fx_delay_line.sv
// Directed bench for fx_delay_line: a frame-indexed delay model pushes expected frames into a
// scoreboard queue that is drained whenever the DUT strobes out_valid.
module tb_fx_delay_line;

  localparam int DATA_W       = 16;
  localparam int PARAM_W      = 7;
  localparam int CHANNELS     = 2;
  localparam int ADDR_W       = 12;
  localparam int CLEAR_CYCLES = CHANNELS * (2 ** ADDR_W);
  localparam int HIST_N       = 8192;

  logic                            clk = 1'b0;
  logic                            reset_n;
  logic                            sample_valid;
  logic [CHANNELS-1:0][DATA_W-1:0] audio_in;
  logic [PARAM_W-1:0]              delay_time;
  logic [PARAM_W-1:0]              feedback;
  logic [PARAM_W-1:0]              mix;
  logic [CHANNELS-1:0][DATA_W-1:0] audio_out;
  logic                            out_valid;
  logic                            busy;

  int checks    = 0;
  int passes    = 0;
  int ov_seen   = 0;
  int n_frames  = 0;
  int out_frame = 0;
  int hist [CHANNELS][HIST_N];
  int exp_q [$];
  int last_out [CHANNELS];

  always #5 clk = ~clk;

  fx_delay_line #(
    .DATA_W   (DATA_W),
    .PARAM_W  (PARAM_W),
    .CHANNELS (CHANNELS),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_valid (sample_valid),
    .audio_in     (audio_in),
    .delay_time   (delay_time),
    .feedback     (feedback),
    .mix          (mix),
    .audio_out    (audio_out),
    .out_valid    (out_valid),
    .busy         (busy)
  );

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  function automatic int reduce16(input int v);
`ifdef FX_DELAY_SAT_EN
    if (v > 32767) return 32767;
    else if (v < -32768) return -32768;
    else return v;
`else
    logic signed [15:0] t;
    t = v[15:0];
    return int'(t);
`endif
  endfunction

  // Reference delay line indexed by frame number since the last clear.
  task automatic model_frame(input int xl, input int xr, input int t, input int fb, input int mx);
    int d, y, w, o;
    int xs [CHANNELS];
    xs[0] = xl;
    xs[1] = xr;
    d = t * 32;
    if (d == 0) d = 1;
    for (int c = 0; c < CHANNELS; c++) begin
      y = (n_frames - d >= 0) ? hist[c][n_frames - d] : 0;
      w = reduce16(xs[c] + ((y * fb) >>> 7));
      o = reduce16((xs[c] * (128 - mx) + y * mx) >>> 7);
      hist[c][n_frames] = w;
      exp_q.push_back(o);
    end
    n_frames++;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (out_valid === 1'b1) begin
      ov_seen++;
      if (exp_q.size() < CHANNELS) begin
        check("unexpected_out_valid", exp_q.size(), CHANNELS);
      end else begin
        for (int c = 0; c < CHANNELS; c++) begin
          last_out[c] = int'($signed(audio_out[c]));
          check($sformatf("out_f%0d_ch%0d", out_frame, c), last_out[c], exp_q.pop_front());
        end
      end
      out_frame++;
    end
  endtask

  task automatic drive(input int xl, input int xr, input int t, input int fb, input int mx);
    audio_in[0] = DATA_W'(xl);
    audio_in[1] = DATA_W'(xr);
    delay_time  = PARAM_W'(t);
    feedback    = PARAM_W'(fb);
    mix         = PARAM_W'(mx);
  endtask

  // One frame: accept, wait for the strobe, then one more cycle back to IDLE.
  task automatic send_frame(input int xl, input int xr, input int t, input int fb, input int mx,
                            input int mid_mix);
    int start, cyc;
    drive(xl, xr, t, fb, mx);
    sample_valid = 1'b1;
    start = ov_seen;
    tick();
    sample_valid = 1'b0;
    model_frame(xl, xr, t, fb, mx);
    cyc = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 2 && mid_mix >= 0) drive(-7777, 5555, 127, 127, mid_mix);
      tick();
      if (ov_seen != start) begin
        cyc = k + 1;
        break;
      end
    end
    check("out_valid_cycle", cyc, 3 * CHANNELS + 1);
    tick();
    check("busy_idle_after_done", int'(busy), 0);
  endtask

  task automatic wait_clear(input string tag);
    int n, start;
    n = 0;
    start = ov_seen;
    while (busy === 1'b1 && n < CLEAR_CYCLES + 100) begin
      sample_valid = (n % 1000 == 500);
      tick();
      n++;
    end
    sample_valid = 1'b0;
    check({tag, "_clear_cycles"}, n, CLEAR_CYCLES);
    check({tag, "_no_out_valid"}, ov_seen - start, 0);
    check({tag, "_out_l_zero"}, int'($signed(audio_out[0])), 0);
    check({tag, "_out_r_zero"}, int'($signed(audio_out[1])), 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    reset_n      = 1'b0;
    sample_valid = 1'b0;
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    check("reset_busy", int'(busy), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_l", int'($signed(audio_out[0])), 0);
    check("reset_out_r", int'($signed(audio_out[1])), 0);
    reset_n = 1'b1;
    wait_clear("por");

    // Impulse through D=32, pure wet path.
    for (int f = 0; f < 64; f++) begin
      send_frame((f == 0) ? 16384 : 0, 0, 1, 0, 127, -1);
      if (f == 0)  check("impulse_f0_l", last_out[0], 128);
      if (f == 32) check("impulse_f32_l", last_out[0], 16256);
    end

    // Abort a frame in cycle 4 (ch0 already written at wr_ptr=64).
    drive(10000, -10000, 126, 0, 0);
    sample_valid = 1'b1;
    start = ov_seen;
    tick();
    sample_valid = 1'b0;
    tick();
    tick();
    tick();
    check("abort_out_l_before_reset", int'($signed(audio_out[0])), 10000);
    reset_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 1);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_out_l_reset", int'($signed(audio_out[0])), 0);
    tick();
    tick();
    check("abort_no_strobe", ov_seen - start, 0);
    check("abort_sb_empty", exp_q.size(), 0);
    reset_n = 1'b1;
    n_frames  = 0;
    out_frame = 0;
    exp_q.delete();
    wait_clear("abort");
    // Tap of D=4032 at wr_ptr=0 lands on the aborted write address.
    send_frame(0, 0, 126, 0, 127, -1);
    check("abort_write_erased", last_out[0], 0);

    // Feedback decay with D=1.
    send_frame(16384, 0, 0, 64, 127, -1);
    send_frame(0, 0, 0, 64, 127, -1);
    check("decay_f1", last_out[0], 16256);
    send_frame(0, 0, 0, 64, 127, -1);
    check("decay_f2", last_out[0], 8128);
    send_frame(0, 0, 0, 64, 127, -1);
    check("decay_f3", last_out[0], 4064);
    for (int f = 0; f < 14; f++) send_frame(0, 0, 0, 64, 127, -1);

    // Overflow of the feedback sum.
    send_frame(30000, 30000, 0, 0, 127, -1);
    send_frame(30000, 30000, 0, 127, 127, -1);
    send_frame(0, 0, 0, 0, 127, -1);
`ifdef FX_DELAY_SAT_EN
    check("overflow_stored_l", last_out[0], 32511);
    check("overflow_stored_r", last_out[1], 32511);
`else
    check("overflow_stored_l", last_out[0], -5726);
    check("overflow_stored_r", last_out[1], -5726);
`endif

    // Control and input changes while a frame is in flight.
    send_frame(1000, -2000, 0, 0, 32, 100);

    // sample_valid held high for 20 cycles.
    drive(1000, -2000, 0, 0, 64);
    start = ov_seen;
    for (int i = 0; i < 30; i++) begin
      sample_valid = (i < 20);
      tick();
      if (i < 20 && i % 8 == 0) model_frame(1000, -2000, 0, 0, 64);
    end
    sample_valid = 1'b0;
    check("held_valid_frames", ov_seen - start, 3);

    // Ramp through D=4064 across the wr_ptr wrap.
    for (int k = 0; k < 5000; k++) begin
      send_frame(k, -k, 127, 0, 127, -1);
      if (k == 4500) check("wrap_k4500_l", last_out[0], (4500 + 436 * 127) >>> 7);
    end

    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
